// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, stack depth and the call/return
// opcodes the control unit decodes into push/pop for pila_retorno.
package cpu_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [3:0] {
        OP_ALU  = 4'h0,
        OP_LOAD = 4'h1,
        OP_STOR = 4'h2,
        OP_BEQ  = 4'h3,
        OP_JMP  = 4'h4,
        OP_JAL  = 4'h5,
        OP_RET  = 4'h6
    } opcode_t;

    // Control-unit helpers: a jal saves PC+1, a ret consumes the saved top.
    function automatic logic is_call(input opcode_t op);
        return op == OP_JAL;
    endfunction

    function automatic logic is_return(input opcode_t op);
        return op == OP_RET;
    endfunction

endpackage

// File: rtl/pila_retorno.sv
// Return-address stack feeding the next-PC mux. Optional sticky ovf/udf
// error flags are built only when PILA_RETORNO_ERR_EN is defined.
module pila_retorno
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       empty,
    output logic                       full,
`ifdef PILA_RETORNO_ERR_EN
    output logic                       ovf,
    output logic                       udf,
`endif
    output logic [$clog2(DEPTH+1)-1:0] nivel
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] ONE     = LW'(1);
    localparam logic [LW-1:0] SP_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    sp;
    logic [LW-1:0]    sp_nxt;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    assign empty = (sp == '0);
    assign full  = (sp == SP_FULL);
    assign nivel = sp;
    assign q     = empty ? '0 : mem[AW'(sp - ONE)];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        wr_en  = 1'b0;
        wr_idx = AW'(sp);
        sp_nxt = sp;
        if (push && pop) begin
            // Replace the top; on an empty stack the pop is dropped and the push lands in slot 0.
            wr_en = 1'b1;
            if (empty) begin
                wr_idx = '0;
                sp_nxt = ONE;
            end else begin
                wr_idx = AW'(sp - ONE);
            end
        end else if (push) begin
            if (!full) begin
                wr_en  = 1'b1;
                sp_nxt = sp + ONE;
            end
        end else if (pop) begin
            if (!empty) begin
                sp_nxt = sp - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sp <= '0;
        end else begin
            sp <= sp_nxt;
        end
    end

    // NOTE: the entry array has no reset; stale entries are hidden by sp/empty, so clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= d;
        end
    end

`ifdef PILA_RETORNO_ERR_EN
    logic ovf_ev;
    logic udf_ev;

    assign ovf_ev = push && !pop && full;
    assign udf_ev = pop && empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_ev) ovf <= 1'b1;
            if (udf_ev) udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pila_retorno.sv
// Self-checking bench for pila_retorno: directed scenarios followed by random
// push/pop traffic, all compared against a queue-based model of the stack.
module tb_pila_retorno;

    localparam int WIDTH = 10;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             full;
    logic [LW-1:0]    nivel;
`ifdef PILA_RETORNO_ERR_EN
    logic             ovf;
    logic             udf;
`endif

    pila_retorno #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .d     (d),
        .q     (q),
        .empty (empty),
        .full  (full),
`ifdef PILA_RETORNO_ERR_EN
        .ovf   (ovf),
        .udf   (udf),
`endif
        .nivel (nivel)
    );

    always #5 clk = ~clk;

    // Reference model: the stack contents as a queue, top at the back.
    logic [WIDTH-1:0] model[$];
    logic             m_ovf;
    logic             m_udf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        return (model.size() > 0) ? model[model.size()-1] : '0;
    endfunction

    task automatic model_update(input logic r, input logic p, input logic po, input logic [WIDTH-1:0] dv);
        if (r) begin
            model.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (p && po) begin
            if (model.size() == 0) begin
                model.push_back(dv);
                m_udf = 1'b1;
            end else begin
                model[model.size()-1] = dv;
            end
        end else if (p) begin
            if (model.size() < DEPTH) model.push_back(dv);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (model.size() > 0) void'(model.pop_back());
            else m_udf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},     32'(q),     32'(model_top()));
        check({tag, ".nivel"}, 32'(nivel), model.size());
        check({tag, ".empty"}, 32'(empty), 32'(model.size() == 0));
        check({tag, ".full"},  32'(full),  32'(model.size() == DEPTH));
`ifdef PILA_RETORNO_ERR_EN
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ".udf"},   32'(udf),   32'(m_udf));
`endif
    endtask

    // One clock cycle: drive, check the zero-latency read, clock, check the new state.
    task automatic step(input string tag, input logic r, input logic p, input logic po,
                        input logic [WIDTH-1:0] dv);
        reset = r;
        push  = p;
        pop   = po;
        d     = dv;
        #1;
        check({tag, ".q_pre"}, 32'(q), 32'(model_top()));
        @(posedge clk);
        model_update(r, p, po, dv);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] vals [3];
        vals[0] = 10'h005;
        vals[1] = 10'h07A;
        vals[2] = 10'h3FF;

        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        d     = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        step("idle", 1'b0, 1'b0, 1'b0, '0);

        // Call chain of three, then unwind.
        for (int i = 0; i < 3; i++) step("push3", 1'b0, 1'b1, 1'b0, vals[i]);
        check("push3.nivel3", 32'(nivel), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            pop = 1'b1;
            push = 1'b0;
            #1;
            check("pop3.ret_addr", 32'(q), 32'(vals[i]));
            step("pop3", 1'b0, 1'b0, 1'b1, '0);
        end
        check("pop3.empty", 32'(empty), 32'd1);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, WIDTH'(10'h100 + i));
        check("fill.full", 32'(full), 32'd1);
        step("ovf", 1'b0, 1'b1, 1'b0, 10'h111);
        check("ovf.top", 32'(q), 32'h107);

        // Underflow cases.
        step("rst1", 1'b1, 1'b0, 1'b0, '0);
        step("udf_pop", 1'b0, 1'b0, 1'b1, '0);
        step("udf_pp", 1'b0, 1'b1, 1'b1, 10'h020);
        check("udf_pp.q", 32'(q), 32'h020);

        // Replace top with simultaneous push+pop.
        step("rst2", 1'b1, 1'b0, 1'b0, '0);
        step("rep0", 1'b0, 1'b1, 1'b0, 10'h010);
        step("rep1", 1'b0, 1'b1, 1'b0, 10'h011);
        step("rep", 1'b0, 1'b1, 1'b1, 10'h2AA);
        check("rep.q", 32'(q), 32'h2AA);
        step("rep_pop", 1'b0, 1'b0, 1'b1, '0);
        check("rep_pop.q", 32'(q), 32'h010);

        // Reset wins over a push mid call chain.
        step("rc0", 1'b0, 1'b1, 1'b0, 10'h0C1);
        step("rc1", 1'b0, 1'b1, 1'b0, 10'h0C2);
        step("rst_push", 1'b1, 1'b1, 1'b0, 10'h0C3);
        check("rst_push.nivel", 32'(nivel), 32'd0);

        // Random traffic, push-biased so full/overflow is reached too.
        for (int i = 0; i < 400; i++) begin
            int unsigned r = $urandom_range(0, 99);
            step("rand", r == 0, r < 55 || r >= 90, r >= 50,
                 WIDTH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
